itof_issue_ctrl: RTL and testbench
==================================

Name: itof_issue_ctrl

Overview:
Issue and result-buffering stage wrapped around the team's pipelined int-to-float converter (itof_pipe).
- Accepts integer operands with a destination tag from the FPU dispatch over a valid/ready handshake.
- Tracks the operand through the converter's single internal register stage.
- Captures each converted result and its tag in a credit-protected FIFO that feeds FPU writeback over valid/ready.

Parameters:
TAG_W, 5, width of destination-register tag carried alongside each operand
DEPTH, 4, result FIFO entries; minimum 2; DEPTH>=3 needed for one-op-per-cycle throughput

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous kill of all in-flight and buffered ops
in_valid  input  1  operand valid from dispatch
in_ready  output  1  block can accept operand this cycle
in_data  input  32  signed two's-complement integer operand
in_tag  input  TAG_W  destination tag
out_valid  output  1  converted result available
out_ready  input  1  writeback accepts result
out_data  output  32  IEEE-754 single result
out_tag  output  TAG_W  tag of out_data
busy  output  1  any op in flight or buffered

Behaviour:
- Clocking and reset: single clock clk; reset rst is asynchronous and active-high. All block registers clear asynchronously on rst: s1_valid=0, s1_tag=0, FIFO pointers=0, occupancy=0, FIFO storage=0. The converter's synchronous active-low reset input is driven with ~rst.
- Outputs during/after reset: out_valid=0, out_data=0, out_tag=0, busy=0. in_ready=0 while rst is high and 1 in the first cycle after release.
- Issue: fire = in_valid & in_ready. The converter operand input is driven with in_data every cycle. The converter registers every cycle, so s1_valid qualifies its output.
- Stage 1 update each cycle: s1_valid<=fire, s1_tag<=in_tag.
- Credit rule: in_ready = ~flush & ~rst & (occ + s1_valid < DEPTH). in_ready never depends on out_ready, so there is no combinational path out_ready->in_ready. The FIFO can never overflow; a write when full is a verification error.
- Enqueue: when s1_valid=1 and flush=0, the converter result and s1_tag are written at wr_ptr, and wr_ptr advances modulo DEPTH.
- Dequeue: out_valid = (occ!=0) & ~flush. out_data/out_tag are driven from registered storage at rd_ptr, with no bypass. On out_valid & out_ready, rd_ptr advances modulo DEPTH.
- Occupancy: occ is $clog2(DEPTH+1) bits wide and counts +1 on enqueue, -1 on dequeue. Simultaneous enqueue and dequeue leave occ unchanged while both pointers advance.
- Latency: issue in cycle t, result written at end of t+1, out_valid=1 in cycle t+2 when the FIFO is empty. Results leave strictly in issue order.
- Throughput: with DEPTH>=3 and out_ready held high, one op per cycle sustained. DEPTH=2 throttles to 2 ops per 3 cycles.
- Flush: in the flush cycle, in_ready=0, out_valid=0, and no enqueue or dequeue occurs. Next cycle: s1_valid=0, occ=0, pointers=0. Storage contents are left stale.
- Backpressure: out_valid/out_data/out_tag hold stable while out_valid=1 & out_ready=0.
- busy = s1_valid | (occ!=0).
- Conversion arithmetic (round-half-up on the first dropped bit; mantissa carry bumps the exponent) is owned by the converter; this block adds no arithmetic.

Test Plan:
- Reset, then in_data=1, tag=3, out_ready=1 → out_valid in cycle t+2 with out_data=0x3F800000, out_tag=3; busy=0 after.
- Back-to-back issue of 100, -1, 0x7FFFFFFF (tags 1,2,3), out_ready=1, DEPTH=4 → in_ready stays 1; outputs 0x42C80000, 0xBF800000, 0x4F000000 on consecutive cycles, tags in order.
- out_ready=0 with continuous in_valid → exactly 4 ops accepted, then in_ready=0. Outputs hold stable. Raise out_ready → 4 results drain in order, and in_ready reasserts the cycle after first dequeue.
- With 2 results buffered and 1 in flight, pulse flush one cycle → out_valid=0 that cycle and after; busy=0 next cycle. A new issue of 1 returns 0x3F800000 at t+2.
- Assert rst asynchronously mid-stream (between clock edges) → out_valid, busy and in_ready drop immediately, without waiting for a clock edge. After release, the FIFO is empty and the first new op's result appears at t+2.
- DEPTH=2, out_ready=1, continuous in_valid → in_ready pattern 1,1,0 repeating; no overflow assertion fires.

Source files
------------

// File: rtl/itof_issue_ctrl.sv
// Issue/result-buffering stage around a one-register int-to-float converter.
// Operands are tracked through the converter and captured in a credit-protected FIFO.

module itof_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  output logic [31:0] f
);

  logic [31:0] f_d;
  logic [31:0] f_q;

  // Round-half-up on the first dropped bit; a mantissa carry-out bumps the exponent.
  function automatic logic [31:0] itof_round(input logic [31:0] val);
    logic        sign;
    logic [31:0] mag;
    logic [31:0] norm;
    logic [4:0]  msb;
    logic [24:0] sum;
    logic [7:0]  expo;
    logic [22:0] mant;
    sign = val[31];
    mag  = sign ? (~val + 32'd1) : val;
    msb  = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb = 5'(i);
    end
    norm = mag << (5'd31 - msb);
    sum  = {1'b0, norm[31:8]} + {24'd0, norm[7]};
    expo = 8'd127 + {3'd0, msb} + {7'd0, sum[24]};
    mant = sum[24] ? sum[23:1] : sum[22:0];
    if (mag == 32'd0) return 32'd0;
    return {sign, expo, mant};
  endfunction

  always_comb begin
    f_d = itof_round(a);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) f_q <= '0;
    else        f_q <= f_d;
  end

  assign f = f_q;

endmodule

module itof_issue_ctrl #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OCC_W:0]   DEPTH_C  = DEPTH[OCC_W:0];
  localparam logic [OCC_W-1:0] OCC_FULL = DEPTH[OCC_W-1:0];
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic             s1_valid_q, s1_valid_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [31:0]      data_mem_q [DEPTH];
  logic [31:0]      data_mem_d [DEPTH];
  logic [TAG_W-1:0] tag_mem_q  [DEPTH];
  logic [TAG_W-1:0] tag_mem_d  [DEPTH];

  logic [31:0] conv_f;
  logic        fire;
  logic        enq;
  logic        deq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  itof_pipe u_itof_pipe (
    .clk   (clk),
    .rst_n (~rst),
    .a     (in_data),
    .f     (conv_f)
  );

  // Credit covers both buffered results and the op still inside the converter.
  assign in_ready  = ~flush & ~rst &
                     (({1'b0, occ_q} + {{OCC_W{1'b0}}, s1_valid_q}) < DEPTH_C);
  assign fire      = in_valid & in_ready;
  assign out_valid = (occ_q != '0) & ~flush;
  assign out_data  = data_mem_q[rd_ptr_q];
  assign out_tag   = tag_mem_q[rd_ptr_q];
  assign busy      = s1_valid_q | (occ_q != '0);
  assign enq       = s1_valid_q & ~flush;
  assign deq       = out_valid & out_ready;

  always_comb begin
    s1_valid_d = fire;
    s1_tag_d   = in_tag;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    data_mem_d = data_mem_q;
    tag_mem_d  = tag_mem_q;
    if (enq) begin
      data_mem_d[wr_ptr_q] = conv_f;
      tag_mem_d[wr_ptr_q]  = s1_tag_q;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({enq, deq})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    // Stale storage is harmless once occupancy is cleared.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= '0;
        tag_mem_q[i]  <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      data_mem_q <= data_mem_d;
      tag_mem_q  <= tag_mem_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(enq && (occ_q == OCC_FULL)));

endmodule

// File: tb/tb_itof_issue_ctrl.sv
// Directed bench for itof_issue_ctrl: DEPTH=4 main instance plus a DEPTH=2 instance.

module tb_itof_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, in_valid, out_ready;
  logic        in_ready, out_valid, busy;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_tag, out_tag;

  logic        b_flush, b_in_valid, b_out_ready;
  logic        b_in_ready, b_out_valid, b_busy;
  logic [31:0] b_in_data, b_out_data;
  logic [4:0]  b_in_tag, b_out_tag;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  itof_issue_ctrl #(.TAG_W(5), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .busy(busy)
  );

  itof_issue_ctrl #(.TAG_W(5), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag),
    .busy(b_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_tag !== 5'd0) begin failures++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    step();
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 32'd1; in_tag = 5'd3; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_inflight got=%b exp=1", busy); end
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 32'h3F800000) begin failures++; $display("FAIL single_data got=%h exp=3f800000", out_data); end
    checks++; if (out_tag !== 5'd3) begin failures++; $display("FAIL single_tag got=%0d exp=3", out_tag); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_after_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_after_busy got=%b exp=0", busy); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    logic [31:0] exps [3];
    vals[0] = 32'd100;      exps[0] = 32'h42C80000;
    vals[1] = 32'hFFFFFFFF; exps[1] = 32'hBF800000;
    vals[2] = 32'h7FFFFFFF; exps[2] = 32'h4F000000;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        in_valid = 1'b1; in_data = vals[c]; in_tag = 5'(c + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 3) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready c=%0d got=%b exp=1", c, in_ready); end
      end
      if (c >= 2 && c <= 4) begin
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid c=%0d got=%b exp=1", c, out_valid); end
        checks++; if (out_data !== exps[c-2]) begin failures++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, out_data, exps[c-2]); end
        checks++; if (out_tag !== 5'(c - 1)) begin failures++; $display("FAIL b2b_tag c=%0d got=%0d exp=%0d", c, out_tag, c - 1); end
      end
      if (c == 5) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid got=%b exp=0", out_valid); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] vals [5];
    logic [31:0] exps [4];
    int acc;
    vals[0] = 32'd5; vals[1] = 32'd6; vals[2] = 32'd7; vals[3] = 32'd8; vals[4] = 32'd9;
    exps[0] = 32'h40A00000; exps[1] = 32'h40C00000; exps[2] = 32'h40E00000; exps[3] = 32'h41000000;
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_data = vals[acc]; in_tag = 5'(4 + acc);
      #1;
      checks++; if (in_ready !== (c < 4)) begin failures++; $display("FAIL bp_in_ready c=%0d got=%b exp=%b", c, in_ready, (c < 4)); end
      if (in_ready) acc++;
      if (c >= 2) begin
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h40A00000 || out_tag !== 5'd4) begin
          failures++; $display("FAIL bp_hold c=%0d got=%b/%h/%0d exp=1/40a00000/4", c, out_valid, out_data, out_tag);
        end
      end
      step();
    end
    checks++; if (acc != 4) begin failures++; $display("FAIL bp_accepted got=%0d exp=4", acc); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_drain_valid k=%0d got=%b exp=1", k, out_valid); end
      checks++; if (out_data !== exps[k]) begin failures++; $display("FAIL bp_drain_data k=%0d got=%h exp=%h", k, out_data, exps[k]); end
      checks++; if (out_tag !== 5'(4 + k)) begin failures++; $display("FAIL bp_drain_tag k=%0d got=%0d exp=%0d", k, out_tag, 4 + k); end
      checks++; if (in_ready !== (k != 0)) begin failures++; $display("FAIL bp_drain_ready k=%0d got=%b exp=%b", k, in_ready, (k != 0)); end
      step();
    end
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b/%b exp=0/0", out_valid, busy); end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = 32'(10 + c); in_tag = 5'(c);
      #1;
      step();
    end
    flush = 1'b1; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_busy_before got=%b exp=1", busy); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_after_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_after_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_after_ready got=%b exp=1", in_ready); end
    in_valid = 1'b1; in_data = 32'd1; in_tag = 5'd9; out_ready = 1'b1;
    #1;
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_reissue_early got=%b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h3F800000 || out_tag !== 5'd9) begin
      failures++; $display("FAIL flush_reissue got=%b/%h/%0d exp=1/3f800000/9", out_valid, out_data, out_tag);
    end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_data = 32'd2; in_tag = 5'(c);
      #1;
      step();
    end
    #1;
    checks++; if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b1) begin
      failures++; $display("FAIL arst_pre got=%b/%b/%b exp=1/1/1", out_valid, busy, in_ready);
    end
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL arst_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL arst_out_data got=%h exp=0", out_data); end
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL arst_release got=%b/%b/%b exp=1/0/0", in_ready, out_valid, busy);
    end
    in_valid = 1'b1; in_data = 32'd7; in_tag = 5'd2;
    #1;
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_new_early got=%b exp=0", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h40E00000 || out_tag !== 5'd2) begin
      failures++; $display("FAIL arst_new got=%b/%h/%0d exp=1/40e00000/2", out_valid, out_data, out_tag);
    end
    step();
  endtask

  task automatic test_depth2();
    logic pat [3];
    int acc;
    int got;
    pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b0;
    acc = 0; got = 0;
    b_out_ready = 1'b1; b_in_data = 32'd1;
    for (int c = 0; c < 9; c++) begin
      b_in_valid = 1'b1; b_in_tag = 5'(acc);
      #1;
      checks++; if (b_in_ready !== pat[c % 3]) begin failures++; $display("FAIL d2_in_ready c=%0d got=%b exp=%b", c, b_in_ready, pat[c % 3]); end
      if (b_in_ready) acc++;
      if (b_out_valid) begin
        checks++; if (b_out_tag !== 5'(got) || b_out_data !== 32'h3F800000) begin
          failures++; $display("FAIL d2_out c=%0d got=%0d/%h exp=%0d/3f800000", c, b_out_tag, b_out_data, got);
        end
        got++;
      end
      step();
    end
    b_in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (b_out_valid) begin
        checks++; if (b_out_tag !== 5'(got)) begin failures++; $display("FAIL d2_drain_tag got=%0d exp=%0d", b_out_tag, got); end
        got++;
      end
      step();
    end
    checks++; if (acc != 6) begin failures++; $display("FAIL d2_accepted got=%0d exp=6", acc); end
    checks++; if (got != acc) begin failures++; $display("FAIL d2_delivered got=%0d exp=%0d", got, acc); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_tag = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0; b_in_tag = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_depth2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
